// File: rtl/reg_file_if.sv
// Register-file access bus: two read ports and one write port.
// The slave modport belongs to the register file, the master to its driver.
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  regwrite;
  logic [ADDR_WIDTH-1:0] rr1;
  logic [ADDR_WIDTH-1:0] rr2;
  logic [ADDR_WIDTH-1:0] wr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;

  modport master (
    output regwrite, rr1, rr2, wr, write_data,
    input  rdata1, rdata2
  );

  modport slave (
    input  regwrite, rr1, rr2, wr, write_data,
    output rdata1, rdata2
  );
endinterface

// File: rtl/reg_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file, r0 hardwired to zero, async reads, sync write.
// Optional macro REGFILE_WRITE_BYPASS_EN adds a same-cycle write-through bypass on both read ports.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic      clock,
  input  logic      reset,
  reg_file_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_rdata1;
  logic [DATA_WIDTH-1:0] w_rdata2;
  logic                  w_write_en;

  // Index 0 is never a write target, so entry 0 only ever holds its reset value.
  assign w_write_en = bus.regwrite && (bus.wr != '0);

  // NOTE: the array is built from flops, not RAM, because reset must clear every entry in one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_en) begin
      r_regs[bus.wr] <= bus.write_data;
    end
  end

  // NOTE: outputs get a default first so no path through this block can infer a latch.
  always_comb begin
    w_rdata1 = (bus.rr1 == '0) ? '0 : r_regs[bus.rr1];
    w_rdata2 = (bus.rr2 == '0) ? '0 : r_regs[bus.rr2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!reset && w_write_en && (bus.rr1 == bus.wr)) begin
      w_rdata1 = bus.write_data;
    end
    if (!reset && w_write_en && (bus.rr2 == bus.wr)) begin
      w_rdata2 = bus.write_data;
    end
`endif
  end

  assign bus.rdata1 = w_rdata1;
  assign bus.rdata2 = w_rdata2;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, read-during-write sequence,
// and randomized traffic compared against an array model of the register contents.
module tb_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2 ** AW;

  logic clock = 1'b0;
  logic reset;

  reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    logic [AW-1:0] rr1;
    logic [AW-1:0] rr2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  vec_t vecs [9];

  logic [DW-1:0] model [NR];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] rr, input logic rst,
                                               input logic we, input logic [AW-1:0] wr,
                                               input logic [DW-1:0] wd);
    logic [DW-1:0] v;
    v = (rr == 0) ? '0 : model[rr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!rst && we && wr != 0 && rr == wr) v = wd;
`endif
    return v;
  endfunction

  initial begin
    vecs[0] = '{1'b0, 1'b1, 5'd16, 32'd100,        5'd16, 5'd17, 32'd100,        32'd0};
    vecs[1] = '{1'b0, 1'b1, 5'd17, 32'd150,        5'd16, 5'd17, 32'd100,        32'd150};
    vecs[2] = '{1'b0, 1'b0, 5'd16, 32'hDEADBEEF,   5'd16, 5'd17, 32'd100,        32'd150};
    vecs[3] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF,   5'd0,  5'd0,  32'd0,          32'd0};
    vecs[4] = '{1'b0, 1'b1, 5'd31, 32'hCAFEF00D,   5'd31, 5'd16, 32'hCAFEF00D,   32'd100};
    vecs[5] = '{1'b0, 1'b1, 5'd16, 32'h00000001,   5'd16, 5'd31, 32'h00000001,   32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b1, 5'd16, 32'd100,        5'd16, 5'd16, 32'd100,        32'd100};
    vecs[7] = '{1'b1, 1'b1, 5'd16, 32'd7,          5'd16, 5'd17, 32'd0,          32'd0};
    vecs[8] = '{1'b0, 1'b1, 5'd1,  32'h00000055,   5'd1,  5'd2,  32'h00000055,   32'd0};

    // Reset for 10 cycles with the write port undriven; it must have no effect.
    reset          = 1'b1;
    bus.regwrite   = 1'bx;
    bus.wr         = 'x;
    bus.write_data = 'x;
    bus.rr1        = 5'd16;
    bus.rr2        = 5'd17;
    repeat (10) tick();
    reset        = 1'b0;
    bus.regwrite = 1'b0;
    bus.wr       = '0;
    bus.write_data = '0;
    #1;
    check("reset_rd1_r16", bus.rdata1, '0);
    check("reset_rd2_r17", bus.rdata2, '0);
    for (int i = 0; i < NR; i++) begin
      bus.rr1 = AW'(i);
      bus.rr2 = AW'(NR - 1 - i);
      #1;
      check($sformatf("reset_sweep1_%0d", i), bus.rdata1, '0);
      check($sformatf("reset_sweep2_%0d", i), bus.rdata2, '0);
    end

    // Directed table: apply one edge of inputs, then read back with regwrite low.
    for (int k = 0; k < 9; k++) begin
      reset          = vecs[k].rst;
      bus.regwrite   = vecs[k].we;
      bus.wr         = vecs[k].wr;
      bus.write_data = vecs[k].wd;
      tick();
      reset        = 1'b0;
      bus.regwrite = 1'b0;
      bus.rr1      = vecs[k].rr1;
      bus.rr2      = vecs[k].rr2;
      #1;
      check($sformatf("vec%0d_rd1", k), bus.rdata1, vecs[k].exp1);
      check($sformatf("vec%0d_rd2", k), bus.rdata2, vecs[k].exp2);
    end

    // Read-during-write on r5 from both ports.
    bus.regwrite   = 1'b1;
    bus.wr         = 5'd5;
    bus.write_data = 32'hA5A5A5A5;
    tick();
    bus.rr1        = 5'd5;
    bus.rr2        = 5'd5;
    bus.write_data = 32'h12345678;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rdw_pre_rd1", bus.rdata1, 32'h12345678);
    check("rdw_pre_rd2", bus.rdata2, 32'h12345678);
`else
    check("rdw_pre_rd1", bus.rdata1, 32'hA5A5A5A5);
    check("rdw_pre_rd2", bus.rdata2, 32'hA5A5A5A5);
`endif
    tick();
    bus.regwrite = 1'b0;
    #1;
    check("rdw_post_rd1", bus.rdata1, 32'h12345678);
    check("rdw_post_rd2", bus.rdata2, 32'h12345678);

    // Index 0 is never bypassed, even while a write to 0 is presented.
    bus.regwrite   = 1'b1;
    bus.wr         = 5'd0;
    bus.write_data = 32'hFFFFFFFF;
    bus.rr1        = 5'd0;
    bus.rr2        = 5'd5;
    #1;
    check("w0_pre_rd1", bus.rdata1, '0);
    check("w0_pre_rd2", bus.rdata2, 32'h12345678);
    tick();
    bus.regwrite = 1'b0;
    #1;
    check("w0_post_rd1", bus.rdata1, '0);

    // Randomized traffic from a clean reset against the array model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int c = 0; c < 2000; c++) begin
      logic          rst;
      logic          we;
      logic [AW-1:0] wr;
      logic [DW-1:0] wd;
      rst = ($urandom_range(0, 63) == 0);
      we  = $urandom_range(0, 1) == 1;
      wr  = AW'($urandom_range(0, NR - 1));
      wd  = $urandom();
      reset          = rst;
      bus.regwrite   = we;
      bus.wr         = wr;
      bus.write_data = wd;
      bus.rr1        = ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, NR - 1));
      bus.rr2        = ($urandom_range(0, 3) == 0) ? wr : AW'($urandom_range(0, NR - 1));
      #1;
      check($sformatf("rand%0d_rd1", c), bus.rdata1, model_read(bus.rr1, rst, we, wr, wd));
      check($sformatf("rand%0d_rd2", c), bus.rdata2, model_read(bus.rr2, rst, we, wr, wd));
      tick();
      if (rst) begin
        for (int i = 0; i < NR; i++) model[i] = '0;
      end else if (we && wr != 0) begin
        model[wr] = wd;
      end
    end

    // Final full sweep of the file after the random phase.
    reset        = 1'b0;
    bus.regwrite = 1'b0;
    for (int i = 0; i < NR; i++) begin
      bus.rr1 = AW'(i);
      bus.rr2 = AW'(i);
      #1;
      check($sformatf("final_rd1_%0d", i), bus.rdata1, (i == 0) ? '0 : model[i]);
      check($sformatf("final_rd2_%0d", i), bus.rdata2, (i == 0) ? '0 : model[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
